multi_port_write_decoder: RTL
=============================

Name: multi_port_write_decoder

Overview:
- Registered, parametrised successor to the register-file write-select decoder.
- Decodes two independent write-select codes (channel A and channel B, for dual writeback) into one combined one-hot-per-channel write-enable vector.
- Adds a per-bit write-protect mask, a stall input backed by a one-entry pending buffer with ready handshake, and same-target conflict detection with a saturating counter.
- Sits between the control unit / writeback stage and the register-file load enables.

Parameters:
- SEL_WIDTH, 4, width of each select code.
- OUT_WIDTH, 16, number of decoded enables; must equal 2**SEL_WIDTH.
- MSB_FIRST, 1, 1: code 0 drives bit OUT_WIDTH-1 (code k drives bit OUT_WIDTH-1-k); 0: code k drives bit k.
- PROTECT_MASK, 16'h0000, bits set here are never asserted on decoder_output.
- CNT_WIDTH, 8, width of conflict_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_enable_a  input  1  channel A write request.
- decoder_control_a  input  SEL_WIDTH  channel A target code.
- load_enable_b  input  1  channel B write request.
- decoder_control_b  input  SEL_WIDTH  channel B target code.
- hold  input  1  downstream stall; freezes decoder_output.
- in_ready  output  1  request accepted this cycle when high; equals !pending_full.
- decoder_output  output  OUT_WIDTH  registered combined write enables.
- conflict  output  1  one-cycle pulse: accepted request had A and B on the same code.
- protect_violation  output  1  one-cycle pulse: accepted request targeted a protected bit.
- conflict_count  output  CNT_WIDTH  saturating count of conflicts.

Behaviour:
- Reset (synchronous, overrides everything): decoder_output=0, pending_full=0, pending_mask=0, conflict=0, protect_violation=0, conflict_count=0. in_ready=1 on the first cycle after reset.
- Request mask (combinational): onehot(code_a) if load_enable_a, OR onehot(code_b) if load_enable_b, then AND ~PROTECT_MASK.
- Accepted request: in_ready=1 and (load_enable_a or load_enable_b). When in_ready=0, both enables are ignored; the request is lost and the upstream must hold it.
- Same code on A and B yields a single bit set. Channel A has nominal priority, but the result is identical.
- Output register update each rising edge, states IDLE/PENDING (pending_full):
  - hold=0, pending_full=0: decoder_output <= request mask, which is 0 with no request. Latency is 1 cycle, pulse-per-request: no request means all zeros, as in the predecessor.
  - hold=0, pending_full=1: decoder_output <= pending_mask; pending_full <= 0. in_ready=0 this cycle.
  - hold=1, pending_full=0, accepted request: pending_mask <= request mask; pending_full <= 1. decoder_output holds.
  - hold=1, pending_full=0, no request: no change.
  - hold=1, pending_full=1: everything holds. in_ready=0.
- A request held in pending appears on decoder_output in the first cycle edge with hold=0; it is never dropped.
- conflict is registered on the accepting edge, visible one cycle after acceptance, and high for exactly one cycle. Requests ignored while in_ready=0 cannot produce conflict or protect_violation.
- conflict_count increments on each conflict pulse and saturates at all-ones with no wrap.
- protect_violation is registered on the accepting edge: any enabled channel whose onehot hits PROTECT_MASK. The protected bit is dropped; the other channel's bit is still delivered.
- Reset mid-stall discards pending_mask; no output is produced for it.
- Codes are full-range (2**SEL_WIDTH = OUT_WIDTH); there is no illegal-code case.

Test Plan:
- Reset, then load_enable_a=1 with code_a=0 for one cycle (defaults) -> next cycle decoder_output=16'h8000; following cycle 16'h0000; conflict=0.
- A code 3, B code 12, same cycle -> decoder_output=16'h1008 one cycle later. With MSB_FIRST=0 -> 16'h1008 also, since bits 12 and 3 are symmetric. Repeat A=1, B=2 -> 16'h6000 (MSB_FIRST=1) vs 16'h0006 (MSB_FIRST=0).
- A and B both code 5 -> decoder_output=16'h0400, conflict pulses one cycle. After 300 such requests -> conflict_count=255 and stays at 255.
- PROTECT_MASK=16'h8000, A code 0 plus B code 1 -> decoder_output=16'h4000, protect_violation=1 for one cycle.
- hold=1 with prior output 16'h0100, then A code 2 -> in_ready drops to 0 next cycle and output stays 16'h0100. A further request (A code 7) is ignored. Release hold -> output 16'h2000 one edge later, in_ready=1 again, and code 7 never appears.
- Pending full with hold=1, assert reset for one cycle -> all outputs 0, in_ready=1, and no 16'h2000 appears after hold is released.

Source files
------------

// File: rtl/multi_port_write_decoder.sv
// Dual-channel register-file write-select decoder with write protection,
// a one-entry stall buffer behind a ready handshake, and A/B conflict counting.
module multi_port_write_decoder #(
    parameter int                   SEL_WIDTH    = 4,
    parameter int                   OUT_WIDTH    = 16,
    parameter bit                   MSB_FIRST    = 1'b1,
    parameter logic [OUT_WIDTH-1:0] PROTECT_MASK = '0,
    parameter int                   CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_enable_a,
    input  logic [SEL_WIDTH-1:0] decoder_control_a,
    input  logic                 load_enable_b,
    input  logic [SEL_WIDTH-1:0] decoder_control_b,
    input  logic                 hold,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] decoder_output,
    output logic                 conflict,
    output logic                 protect_violation,
    output logic [CNT_WIDTH-1:0] conflict_count
);

    // Handshake: a request (either load enable high) is taken on a rising
    // edge only while in_ready is high; otherwise it is dropped and the
    // upstream must keep presenting it. in_ready is low exactly while the
    // pending buffer is occupied.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   out_q, out_d;
    logic [OUT_WIDTH-1:0]   pend_q, pend_d;
    logic                   conflict_q, conflict_d;
    logic                   pv_q, pv_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [OUT_WIDTH-1:0]   onehot_a, onehot_b, raw_mask, req_mask;
    logic                   accept;

    // OUT_WIDTH == 2**SEL_WIDTH, so OUT_WIDTH-1-code is simply ~code.
    function automatic logic [OUT_WIDTH-1:0] onehot(input logic [SEL_WIDTH-1:0] code);
        logic [OUT_WIDTH-1:0] v;
        v = '0;
        if (MSB_FIRST) v[~code] = 1'b1;
        else           v[code]  = 1'b1;
        return v;
    endfunction

    assign onehot_a = load_enable_a ? onehot(decoder_control_a) : '0;
    assign onehot_b = load_enable_b ? onehot(decoder_control_b) : '0;
    assign raw_mask = onehot_a | onehot_b;
    assign req_mask = raw_mask & ~PROTECT_MASK;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_ready && (load_enable_a || load_enable_b);

    assign conflict_d = accept && load_enable_a && load_enable_b &&
                        (decoder_control_a == decoder_control_b);
    assign pv_d       = accept && |(raw_mask & PROTECT_MASK);
    assign cnt_d      = (conflict_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                // With no request req_mask is zero, giving pulse-per-request output.
                if (!hold) begin
                    out_d = req_mask;
                end else if (accept) begin
                    pend_d  = req_mask;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (!hold) begin
                    out_d   = pend_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            out_q      <= '0;
            pend_q     <= '0;
            conflict_q <= 1'b0;
            pv_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
            pv_q       <= pv_d;
            cnt_q      <= cnt_d;
        end
    end

    assign decoder_output    = out_q;
    assign conflict          = conflict_q;
    assign protect_violation = pv_q;
    assign conflict_count    = cnt_q;

endmodule
